// File: rtl/uart_tx_if.sv
// FIFO read-side handshake between the TX FIFO and the UART transmitter.
// The transmitter is the master: it issues the pop strobe. The FIFO is the
// slave: it presents the empty flag and its asynchronous read data.
interface uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter sitting directly behind the TX FIFO.
// Frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// A new byte is popped either from IDLE or on the final STOP cycle, so queued
// frames are sent back-to-back with no idle gap.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_tx_if.master fifo,
  output logic      tx,
  output logic      tx_busy,
  output logic      tx_done
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_ZERO = BW'(0);
  localparam logic [BW-1:0]  BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  // Cycle before the last one of a bit; tx_done is launched here so that the
  // registered pulse coincides with the final stop cycle (and any next pop).
  localparam logic [BW-1:0]  BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic           ODD_SEL   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
  localparam logic           PAR_ON    = (PARITY_EN != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          state_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_idx_q;   // data bit index in DATA, stop bit index in STOP
  logic [7:0]      data_q;      // byte captured at the pop edge
  logic            tx_q;
  logic            tx_busy_q;
  logic            tx_done_q;

  logic            bit_end_s;
  logic            stop_last_s;
  logic            load_s;

  // Parity bit for a byte: even parity by default, inverted for odd parity.
  function automatic logic parity_bit(input logic [7:0] d);
    return (^d) ^ ODD_SEL;
  endfunction

  assign bit_end_s   = (baud_q == BAUD_LAST);
  assign stop_last_s = (state_q == S_STOP) && bit_end_s && (bit_idx_q == STOP_LAST);
  assign load_s      = rst_n && !fifo.fifo_empty && ((state_q == S_IDLE) || stop_last_s);

  assign fifo.fifo_rd_en = load_s;
  assign tx              = tx_q;
  assign tx_busy         = tx_busy_q;
  assign tx_done         = tx_done_q;

  // Frame sequencer: state, baud/bit counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= BAUD_ZERO;
      bit_idx_q <= 3'd0;
      data_q    <= 8'h00;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          baud_q    <= BAUD_ZERO;
          bit_idx_q <= 3'd0;
          if (load_s) begin
            data_q    <= fifo.fifo_rd_data;
            state_q   <= S_START;
            tx_q      <= 1'b0;
            tx_busy_q <= 1'b1;
          end else begin
            tx_q      <= 1'b1;
            tx_busy_q <= 1'b0;
          end
        end

        S_START: begin
          if (bit_end_s) begin
            state_q   <= S_DATA;
            baud_q    <= BAUD_ZERO;
            bit_idx_q <= 3'd0;
            tx_q      <= data_q[0];
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end

        S_DATA: begin
          if (bit_end_s) begin
            baud_q <= BAUD_ZERO;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= 3'd0;
              if (PAR_ON) begin
                state_q <= S_PARITY;
                tx_q    <= parity_bit(data_q);
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= data_q[bit_idx_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end

        S_PARITY: begin
          if (bit_end_s) begin
            state_q   <= S_STOP;
            baud_q    <= BAUD_ZERO;
            bit_idx_q <= 3'd0;
            tx_q      <= 1'b1;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end

        S_STOP: begin
          if (bit_end_s) begin
            baud_q <= BAUD_ZERO;
            if (bit_idx_q == STOP_LAST) begin
              bit_idx_q <= 3'd0;
              if (load_s) begin
                // Back-to-back frame: the next start bit follows immediately.
                data_q    <= fifo.fifo_rd_data;
                state_q   <= S_START;
                tx_q      <= 1'b0;
                tx_busy_q <= 1'b1;
              end else begin
                state_q   <= S_IDLE;
                tx_q      <= 1'b1;
                tx_busy_q <= 1'b0;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
            if ((bit_idx_q == STOP_LAST) && (baud_q == BAUD_PRE)) begin
              tx_done_q <= 1'b1;
            end else begin
              tx_done_q <= 1'b0;
            end
          end
        end

        default: begin
          state_q   <= S_IDLE;
          baud_q    <= BAUD_ZERO;
          bit_idx_q <= 3'd0;
          tx_q      <= 1'b1;
          tx_busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
